// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage pipeline.
// It also keeps a small event FSM, saturating debug counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR    = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_ADDR-1:0]  id_rs_addr,
  input  logic [REG_ADDR-1:0]  id_rt_addr,
  input  logic                 id_uses_rt,
  input  logic [REG_ADDR-1:0]  ex_rs_addr,
  input  logic [REG_ADDR-1:0]  ex_rt_addr,
  input  logic                 ex_mem_r,
  input  logic                 ex_reg_w,
  input  logic [REG_ADDR-1:0]  ex_wb_addr,
  input  logic                 mem_reg_w,
  input  logic [REG_ADDR-1:0]  mem_wb_addr,
  input  logic                 wb_reg_w,
  input  logic [REG_ADDR-1:0]  wb_addr,
  input  logic                 mem_branch_taken,
  input  logic                 mem_jump,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 exmem_flush,
  output logic                 memwb_bubble,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_timeout
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                load_use;
  logic                mem_busy;
  logic                redirect;
  logic                inc_stall;
  logic                inc_flush;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // EX/MEM has the younger result, so it beats MEM/WB; r0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR-1:0] src);
    if (mem_reg_w && (mem_wb_addr != '0) && (mem_wb_addr == src))
      return 2'b10;
    else if (wb_reg_w && (wb_addr != '0) && (wb_addr == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign load_use = ex_mem_r && ex_reg_w && (ex_wb_addr != '0) &&
                    ((ex_wb_addr == id_rs_addr) || (id_uses_rt && (ex_wb_addr == id_rt_addr)));
  assign mem_busy = dmem_req && !dmem_ready;
  assign redirect = mem_branch_taken || mem_jump;

  assign fwd_a = fwd_sel(ex_rs_addr);
  assign fwd_b = fwd_sel(ex_rt_addr);
  assign state = state_q;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    inc_stall    = 1'b0;
    inc_flush    = 1'b0;
    state_d      = RUN;
    if (mem_busy) begin
      // Whole front end freezes; pending redirect/load-use is re-seen once memory completes.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = MEM_WAIT;
    end else if (redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      inc_flush   = 1'b1;
      state_d     = FLUSH;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      inc_stall  = 1'b1;
      state_d    = LU_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (inc_stall) stall_cnt <= sat_inc(stall_cnt);
      if (inc_flush) flush_cnt <= sat_inc(flush_cnt);
      if (mem_busy) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
        // Flag on the edge that completes the MEM_TIMEOUT-th consecutive busy cycle.
        if (wait_cnt >= WAIT_PRE) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule
